seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Sequential controller that drives the team's combinational BCD-to-7-segment decoder on a multiplexed common-anode display.
- Accepts a binary value through a load handshake and converts it to packed BCD with an iterative shift-add-3 (double dabble) engine, one bit per clock.
- Commits the result atomically, then time-multiplexes the digits: one BCD nibble plus one active-low anode enable at a time.
- Sits between user logic (counters, switches) and the decoder/anode pins.

Parameters:
- BIN_W, 14, width of binary input; max displayable value is 10^DIGITS-1.
- DIGITS, 4, number of display digits / BCD nibbles.
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; legal range 1 up to any value that fits the counter.
- LZB, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- bin_in  in  BIN_W  binary value to display
- load  in  1  request to convert bin_in; sampled only in IDLE
- busy  out  1  high while a conversion is in progress
- ready  out  1  one-cycle pulse when a new value is committed
- overflow  out  1  sticky until the next accepted load: last accepted bin_in exceeded 10^DIGITS-1
- bcd_out  out  4*DIGITS  committed packed BCD; digit 0 (units) in [3:0]
- digit_bcd  out  4  nibble for the external decoder, for the currently scanned digit
- an  out  DIGITS  active-low anode enables; at most one bit low at a time

Behaviour:
- Reset (rst_n=0 at a clock edge): FSM=IDLE, busy=0, ready=0, overflow=0, bcd_out=0, scan index=0, refresh counter=0.
  - Outputs after reset: digit_bcd=0, an = all ones except bit 0 low (4'b1110 for DIGITS=4).
  - Reset mid-conversion aborts the conversion; no commit occurs.
- FSM IDLE:
  - load=1 at edge T0: capture bin_in. If bin_in > 10^DIGITS-1, capture 10^DIGITS-1 and set overflow; otherwise clear overflow.
  - Clear the shift/BCD work registers, set busy=1, go to CONVERT.
- FSM CONVERT: BIN_W iterations, one per edge (T1..T_BIN_W).
  - Each iteration adds 3 to every work nibble >=5, then shifts {work, bin} left by 1.
  - After the last iteration, go to COMMIT.
- FSM COMMIT (edge T_BIN_W+1): copy work to bcd_out, ready=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: bcd_out and ready are updated BIN_W+1 edges after the load edge. For defaults that is 15 edges; throughput is one conversion per BIN_W+2 cycles.
- load while busy=1 is ignored and not queued. load held high in IDLE at the commit-return edge starts a new conversion on the next edge.
- Scanning runs continuously and independently of the FSM, always from the committed bcd_out, never from work registers.
  - Refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the index advances idx -> (idx+1) mod DIGITS; DIGITS-1 wraps to 0.
  - digit_bcd = bcd_out nibble[idx]; an[idx]=0 and all other bits 1. Both are combinational from registered idx/bcd_out, so they change in the same cycle idx changes.
- Blanking (LZB=1): digit k>0 is blanked (an[k]=1, digit_bcd still driven) when nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- A commit coinciding with a refresh wrap: the new index and the new bcd_out both take effect on that same edge.
- bcd_out nibbles are always 0..9, so the decoder's undefined-code default is never exercised.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> busy=0, ready=0, bcd_out=16'h0000, an=4'b1110, digit_bcd=0.
- Conversion: load=1 for 1 cycle with bin_in=1234 -> busy=1 for 15 cycles; ready pulses 1 cycle; bcd_out=16'h1234; overflow=0.
- Scan (REFRESH_DIV=4, value 1234): an sequence 1110,1101,1011,0111 with digit_bcd 4,3,2,1, 4 cycles each, then wraps to 1110.
  - Blanking at value 7: an is low only for digit 0; slots 1-3 show an=4'b1111.
- Overflow and busy guard: bin_in=12000 -> bcd_out=16'h9999, overflow=1.
  - A second load with bin_in=5 while busy is ignored; bcd_out stays 16'h9999.
  - Then a load of 5 in IDLE -> bcd_out=16'h0005, overflow=0.
- Reset mid-operation: load bin_in=4321, assert rst_n=0 at cycle 7 of CONVERT -> no ready pulse; bcd_out=0, FSM=IDLE.
  - Then a load of 9999 -> bcd_out=16'h9999.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Load/convert handshake and display scan bus between user logic and seg_scan_ctrl.
// master = user/display side, slave = controller.
interface seg_scan_ctrl_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic [BIN_W-1:0]    bin_in;
  logic                load;
  logic                busy;
  logic                ready;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd_out;
  logic [3:0]          digit_bcd;
  logic [DIGITS-1:0]   an;

  modport master (
    output bin_in, load,
    input  busy, ready, overflow, bcd_out, digit_bcd, an
  );

  modport slave (
    input  bin_in, load,
    output busy, ready, overflow, bcd_out, digit_bcd, an
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Binary-to-BCD (double dabble, one bit/clk) with atomic commit and multiplexed digit scan.
// Commit BIN_W+1 edges after load; loads while busy are dropped, scan never stalls.
module seg_scan_ctrl #(
  parameter int BIN_W       = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int LZB         = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int          BW      = 4 * DIGITS;
  localparam int          CW      = $clog2(BIN_W + 1);
  localparam int          RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int          IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]    work_q, work_d;
  logic [BW-1:0]    work_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ready_q, ready_d;
  logic             ovf_q, ovf_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy;
  logic [3:0]       digit_bcd;
  logic [DIGITS-1:0] an;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.load) state_d = S_CONVERT;
      S_CONVERT: if (cnt_q == CW'(BIN_W - 1)) state_d = S_COMMIT;
      S_COMMIT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    bin_d    = bin_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ready_d  = 1'b0;
    ovf_d    = ovf_q;
    work_adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) work_adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          // Saturate so the BCD result always fits DIGITS nibbles
          if (32'(bus.bin_in) > MAX_VAL) begin
            bin_d = BIN_W'(MAX_VAL);
            ovf_d = 1'b1;
          end else begin
            bin_d = bus.bin_in;
            ovf_d = 1'b0;
          end
          work_d = '0;
          cnt_d  = '0;
        end
      end
      S_CONVERT: begin
        work_d = {work_adj[BW-2:0], bin_q[BIN_W-1]};
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
      end
      S_COMMIT: begin
        bcd_d   = work_q;
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
    end else begin
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
    end
  end

  // Digit k>0 goes dark when it and every higher nibble are zero
  always_comb begin
    digit_bcd = '0;
    an        = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        digit_bcd = bcd_q[4*k +: 4];
        if (LZB == 1 && k > 0 && (bcd_q >> (4*k)) == '0) an = '1;
        else                                             an = ~(DIGITS'(1) << k);
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.ready     = ready_q;
  assign bus.overflow  = ovf_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.digit_bcd = digit_bcd;
  assign bus.an        = an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: conversion, saturation, busy guard, scan/blanking, mid-convert reset.
module tb_seg_scan_ctrl;
  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .BIN_W(BIN_W), .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .LZB(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((s / (10 ** k)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] exp_an(input int v, input int idx);
    logic [3:0] one;
    one = 4'b0001;
    if (idx > 0 && v < 10 ** idx) return 4'b1111;
    return ~(one << idx);
  endfunction

  // Scan position model: edges since the last reset edge
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && bus.ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ready", bus.ready, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("bcd_out", bus.bcd_out, e.bcd);
        chk("overflow", bus.overflow, e.ovf);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v, input bit accept);
    exp_t e;
    bus.bin_in = 14'(v);
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
    if (accept) begin
      e.bcd = to_bcd(v);
      e.ovf = (v > 9999);
      sb_q.push_back(e);
      chk("busy_after_load", bus.busy, 1'b1);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int n = 0;
    int busy_n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.ready === 1'b1)     seen = 1;
      else if (bus.busy === 1'b1) busy_n++;
    end
    chk({tag, "_done"}, seen, 1'b1);
    chk({tag, "_busy_cycles"}, busy_n, exp_busy);
  endtask

  task automatic scan_check(input string tag, input int v, input int n);
    int idx;
    int s;
    s = (v > 9999) ? 9999 : v;
    repeat (n) begin
      @(negedge clk);
      idx = (cyc / RDIV) % DIGITS;
      chk({tag, "_an"}, bus.an, exp_an(s, idx));
      chk({tag, "_digit"}, bus.digit_bcd, (s / (10 ** idx)) % 10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.bin_in = '0;
    bus.load   = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_bcd", bus.bcd_out, 16'h0000);
    chk("rst_an", bus.an, 4'b1110);
    chk("rst_digit", bus.digit_bcd, 4'd0);

    do_load(1234, 1);
    wait_done("conv1234", 15);
    scan_check("scan1234", 1234, 20);

    do_load(7, 1);
    wait_done("conv7", 15);
    scan_check("blank7", 7, 16);

    do_load(12000, 1);
    repeat (3) step();
    do_load(5, 0);
    wait_done("ovf", 11);
    repeat (20) step();
    chk("busy_guard_bcd", bus.bcd_out, 16'h9999);
    chk("busy_guard_ovf", bus.overflow, 1'b1);

    do_load(5, 1);
    wait_done("conv5", 15);
    scan_check("blank5", 5, 8);

    do_load(4321, 1);
    repeat (6) step();
    rst_n = 1'b0;
    sb_q.delete();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_bcd", bus.bcd_out, 16'h0000);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_ready", bus.ready, 1'b0);
    chk("midrst_an", bus.an, 4'b1110);
    repeat (25) step();
    chk("midrst_hold_bcd", bus.bcd_out, 16'h0000);

    do_load(9999, 1);
    wait_done("conv9999", 15);
    scan_check("scan9999", 9999, 8);

    step();
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
